// File: rtl/msx_layout_sequencer.sv
// Boot-time layout builder: turns machine-config records into block table entries,
// slot/page map writes and DDR3->SDRAM copy requests for ROM images.
module msx_layout_sequencer #(
  parameter int SDRAM_BLOCKS = 2048,
  parameter int MAX_IDS      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [4:0]  cfg_typ,
  input  logic [7:0]  cfg_block_count,
  input  logic [1:0]  cfg_slot,
  input  logic [1:0]  cfg_sub_slot,
  input  logic [1:0]  cfg_start_block,
  input  logic        cfg_internal_mapper,
  input  logic [27:0] cfg_store_address,
  input  logic        cfg_last,
  output logic        blk_we,
  output logic [3:0]  blk_id,
  output logic [1:0]  blk_typ,
  output logic [7:0]  blk_count,
  output logic [24:0] blk_offset,
  output logic        map_we,
  output logic [1:0]  map_slot,
  output logic [1:0]  map_subslot,
  output logic [1:0]  map_page,
  output logic [1:0]  map_offset,
  output logic [3:0]  map_block_id,
  output logic        map_init,
  output logic        copy_req,
  input  logic        copy_ack,
  input  logic        copy_done,
  output logic [27:0] copy_src,
  output logic [24:0] copy_dst,
  output logic [7:0]  copy_len,
  output logic        done,
  output logic [1:0]  err
);

  localparam logic [4:0] CT_NONE   = 5'd0;
  localparam logic [4:0] CT_RAM    = 5'd1;
  localparam logic [4:0] CT_BIOS   = 5'd2;
  localparam logic [4:0] CT_FDC    = 5'd3;
  localparam logic [4:0] CT_CART_A = 5'd4;
  localparam logic [4:0] CT_CART_B = 5'd5;

  localparam logic [1:0] BT_RAM = 2'd0;
  localparam logic [1:0] BT_ROM = 2'd1;
  localparam logic [1:0] BT_FDC = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR_BLK, S_MAP, S_COPY_REQ, S_COPY_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  typ_q, typ_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  slot_q, slot_d;
  logic [1:0]  sub_q, sub_d;
  logic [1:0]  start_blk_q, start_blk_d;
  logic        imap_q, imap_d;
  logic [27:0] addr_q, addr_d;
  logic        last_q, last_d;
  logic [1:0]  page_q, page_d;
  logic [1:0]  page_end_q, page_end_d;
  logic        first_q, first_d;
  logic [24:0] off_q, off_d;
  logic [4:0]  next_id_q, next_id_d;
  logic [11:0] next_blk_q, next_blk_d;
  logic [1:0]  err_q, err_d;

  logic        is_fdc, is_rom;
  logic [12:0] alloc_end;
  logic [8:0]  page_sum;
  logic [24:0] win_offset;
  logic [1:0]  rec_blk_typ;
  state_t      after_rec;

  always_comb begin
    is_fdc     = (typ_q == CT_FDC);
    is_rom     = (typ_q == CT_BIOS) || (typ_q == CT_CART_A) || (typ_q == CT_CART_B);
    // 13-bit sum so a nearly full layout cannot wrap past the capacity check
    alloc_end  = {1'b0, next_blk_q} + {5'd0, count_q};
    page_sum   = {7'd0, start_blk_q} + {1'b0, count_q};
    win_offset = is_fdc ? 25'd0 : {next_blk_q[10:0], 14'd0};
    after_rec  = last_q ? S_DONE : S_IDLE;
    if (is_fdc)      rec_blk_typ = BT_FDC;
    else if (is_rom) rec_blk_typ = BT_ROM;
    else             rec_blk_typ = BT_RAM;
  end

  always_comb begin
    state_d     = state_q;
    typ_d       = typ_q;
    count_d     = count_q;
    slot_d      = slot_q;
    sub_d       = sub_q;
    start_blk_d = start_blk_q;
    imap_d      = imap_q;
    addr_d      = addr_q;
    last_d      = last_q;
    page_d      = page_q;
    page_end_d  = page_end_q;
    first_d     = first_q;
    off_d       = off_q;
    next_id_d   = next_id_q;
    next_blk_d  = next_blk_q;
    err_d       = err_q;

    cfg_ready    = 1'b0;
    blk_we       = 1'b0;
    blk_id       = 4'd0;
    blk_typ      = 2'd0;
    blk_count    = 8'd0;
    blk_offset   = 25'd0;
    map_we       = 1'b0;
    map_slot     = 2'd0;
    map_subslot  = 2'd0;
    map_page     = 2'd0;
    map_offset   = 2'd0;
    map_block_id = 4'd0;
    map_init     = 1'b0;
    copy_req     = 1'b0;
    copy_src     = 28'd0;
    copy_dst     = 25'd0;
    copy_len     = 8'd0;

    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          typ_d       = cfg_typ;
          count_d     = cfg_block_count;
          slot_d      = cfg_slot;
          sub_d       = cfg_sub_slot;
          start_blk_d = cfg_start_block;
          imap_d      = cfg_internal_mapper;
          addr_d      = cfg_store_address;
          last_d      = cfg_last;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (typ_q == CT_NONE) begin
          state_d = after_rec;
        end else if (count_q == 8'd0) begin
          err_d   = 2'd3;
          state_d = S_ERROR;
        end else if (next_id_q == 5'(MAX_IDS)) begin
          err_d   = 2'd1;
          state_d = S_ERROR;
        end else if (!is_fdc && (alloc_end > 13'(SDRAM_BLOCKS))) begin
          err_d   = 2'd2;
          state_d = S_ERROR;
        end else begin
          state_d = S_WR_BLK;
        end
      end
      S_WR_BLK: begin
        blk_we     = 1'b1;
        blk_id     = next_id_q[3:0];
        blk_typ    = rec_blk_typ;
        blk_count  = count_q;
        blk_offset = win_offset;
        off_d      = win_offset;
        next_id_d  = next_id_q + 5'd1;
        if (!is_fdc) next_blk_d = alloc_end[11:0];
        // Pages past 3 are clipped rather than wrapping back to page 0
        page_d     = imap_q ? 2'd0 : start_blk_q;
        page_end_d = (imap_q || page_sum >= 9'd4) ? 2'd3 : (page_sum[1:0] - 2'd1);
        first_d    = 1'b1;
        state_d    = S_MAP;
      end
      S_MAP: begin
        map_we       = 1'b1;
        map_slot     = slot_q;
        map_subslot  = sub_q;
        map_page     = page_q;
        map_offset   = imap_q ? page_q : (page_q - start_blk_q);
        map_block_id = off_id(next_id_q);
        map_init     = first_q;
        first_d      = 1'b0;
        if (page_q == page_end_q) state_d = is_rom ? S_COPY_REQ : after_rec;
        else                      page_d  = page_q + 2'd1;
      end
      S_COPY_REQ: begin
        copy_req = 1'b1;
        copy_src = addr_q;
        copy_dst = off_q;
        copy_len = count_q;
        if (copy_ack) state_d = copy_done ? after_rec : S_COPY_WAIT;
      end
      S_COPY_WAIT: begin
        if (copy_done) state_d = after_rec;
      end
      default: ;
    endcase

    // start outranks everything, including a copy still in flight
    if (start) begin
      state_d    = S_IDLE;
      next_id_d  = 5'd0;
      next_blk_d = 12'd0;
      err_d      = 2'd0;
    end
  end

  // The ID written during WR_BLK has already been consumed by the time MAP runs
  function automatic logic [3:0] off_id(input logic [4:0] nid);
    logic [4:0] cur;
    cur    = nid - 5'd1;
    off_id = cur[3:0];
  endfunction

  assign done = (state_q == S_DONE);
  assign err  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      typ_q       <= 5'd0;
      count_q     <= 8'd0;
      slot_q      <= 2'd0;
      sub_q       <= 2'd0;
      start_blk_q <= 2'd0;
      imap_q      <= 1'b0;
      addr_q      <= 28'd0;
      last_q      <= 1'b0;
      page_q      <= 2'd0;
      page_end_q  <= 2'd0;
      first_q     <= 1'b0;
      off_q       <= 25'd0;
      next_id_q   <= 5'd0;
      next_blk_q  <= 12'd0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      typ_q       <= typ_d;
      count_q     <= count_d;
      slot_q      <= slot_d;
      sub_q       <= sub_d;
      start_blk_q <= start_blk_d;
      imap_q      <= imap_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      page_q      <= page_d;
      page_end_q  <= page_end_d;
      first_q     <= first_d;
      off_q       <= off_d;
      next_id_q   <= next_id_d;
      next_blk_q  <= next_blk_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_msx_layout_sequencer.sv
// Directed bench for msx_layout_sequencer: record sequences with hand-computed
// block table, slot map and copy expectations.
module tb_msx_layout_sequencer;

  localparam logic [4:0] T_NONE = 5'd0, T_RAM = 5'd1, T_BIOS = 5'd2, T_FDC = 5'd3, T_CARTA = 5'd4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cfg_valid = 1'b0, cfg_ready;
  logic [4:0]  cfg_typ = '0;
  logic [7:0]  cfg_block_count = '0;
  logic [1:0]  cfg_slot = '0, cfg_sub_slot = '0, cfg_start_block = '0;
  logic        cfg_internal_mapper = 1'b0, cfg_last = 1'b0;
  logic [27:0] cfg_store_address = '0;
  logic        blk_we, map_we, map_init, copy_req, done;
  logic [3:0]  blk_id, map_block_id;
  logic [1:0]  blk_typ, map_slot, map_subslot, map_page, map_offset, err;
  logic [7:0]  blk_count, copy_len;
  logic [24:0] blk_offset, copy_dst;
  logic [27:0] copy_src;
  logic        copy_ack = 1'b0, copy_done = 1'b0;

  int passed = 0, total = 0, cyc = 0;

  msx_layout_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_typ(cfg_typ), .cfg_block_count(cfg_block_count), .cfg_slot(cfg_slot),
    .cfg_sub_slot(cfg_sub_slot), .cfg_start_block(cfg_start_block),
    .cfg_internal_mapper(cfg_internal_mapper), .cfg_store_address(cfg_store_address),
    .cfg_last(cfg_last), .blk_we(blk_we), .blk_id(blk_id), .blk_typ(blk_typ),
    .blk_count(blk_count), .blk_offset(blk_offset), .map_we(map_we), .map_slot(map_slot),
    .map_subslot(map_subslot), .map_page(map_page), .map_offset(map_offset),
    .map_block_id(map_block_id), .map_init(map_init), .copy_req(copy_req),
    .copy_ack(copy_ack), .copy_done(copy_done), .copy_src(copy_src), .copy_dst(copy_dst),
    .copy_len(copy_len), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log captured on the falling edge
  logic [3:0]  lb_id  [256];
  logic [1:0]  lb_typ [256];
  logic [7:0]  lb_cnt [256];
  logic [24:0] lb_off [256];
  int          lb_cyc [256];
  logic [1:0]  lm_slot[256], lm_sub[256], lm_page[256], lm_off[256];
  logic [3:0]  lm_id  [256];
  logic        lm_init[256];
  int          lm_cyc [256];
  int blk_n = 0, map_n = 0, copy_n = 0;
  logic creq_prev = 1'b0;

  always @(negedge clk) begin
    if (blk_we && blk_n < 256) begin
      lb_id[blk_n] = blk_id; lb_typ[blk_n] = blk_typ; lb_cnt[blk_n] = blk_count;
      lb_off[blk_n] = blk_offset; lb_cyc[blk_n] = cyc; blk_n++;
    end
    if (map_we && map_n < 256) begin
      lm_slot[map_n] = map_slot; lm_sub[map_n] = map_subslot; lm_page[map_n] = map_page;
      lm_off[map_n] = map_offset; lm_id[map_n] = map_block_id; lm_init[map_n] = map_init;
      lm_cyc[map_n] = cyc; map_n++;
    end
    if (copy_req && !creq_prev) copy_n++;
    creq_prev = copy_req;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic send(input logic [4:0] typ, input logic [7:0] cnt, input logic [1:0] slot,
                      input logic [1:0] sub, input logic [1:0] sb, input logic imap,
                      input logic [27:0] addr, input logic last, output int acc);
    int n;
    @(negedge clk);
    cfg_typ = typ; cfg_block_count = cnt; cfg_slot = slot; cfg_sub_slot = sub;
    cfg_start_block = sb; cfg_internal_mapper = imap; cfg_store_address = addr; cfg_last = last;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 40) begin @(negedge clk); n++; end
    acc = cyc;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL send_accept cfg_ready=%b expected 1", cfg_ready);
    else passed++;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_settle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cfg_ready || done || err != 2'd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_copy(output bit ok, output int c);
    ok = 1'b0; c = 0;
    for (int i = 0; i < 100; i++) begin
      if (copy_req) begin ok = 1'b1; c = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (cfg_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", cfg_ready); else passed++;
    total++; if ({blk_we, map_we, copy_req, done} !== 4'b0) $display("FAIL rst_strobes got %b exp 0000", {blk_we, map_we, copy_req, done}); else passed++;
    total++; if (err !== 2'd0) $display("FAIL rst_err got %0d exp 0", err); else passed++;
    total++; if (blk_offset !== 25'd0 || copy_src !== 28'd0) $display("FAIL rst_data got %h/%h exp 0", blk_offset, copy_src); else passed++;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_bios();
    int b0 = blk_n, m0 = map_n, c0 = copy_n, acc, cc; bit ok;
    send(T_BIOS, 8'd2, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0100000, 1'b0, acc);
    wait_copy(ok, cc);
    total++; if (!ok) $display("FAIL bios_copy_req got timeout exp copy_req"); else passed++;
    total++; if (cc !== acc + 5) $display("FAIL bios_copy_lat got %0d exp %0d", cc - acc, 5); else passed++;
    total++; if (copy_src !== 28'h0100000 || copy_dst !== 25'd0 || copy_len !== 8'd2) $display("FAIL bios_copy_fields got %h/%h/%0d exp 0100000/0/2", copy_src, copy_dst, copy_len); else passed++;
    total++; if (blk_n - b0 !== 1) $display("FAIL bios_blk_n got %0d exp 1", blk_n - b0); else passed++;
    total++; if (lb_id[b0] !== 4'd0 || lb_typ[b0] !== 2'd1 || lb_cnt[b0] !== 8'd2 || lb_off[b0] !== 25'd0) $display("FAIL bios_blk got id%0d typ%0d cnt%0d off%h exp id0 typ1 cnt2 off0", lb_id[b0], lb_typ[b0], lb_cnt[b0], lb_off[b0]); else passed++;
    total++; if (lb_cyc[b0] !== acc + 2) $display("FAIL bios_blk_lat got %0d exp 2", lb_cyc[b0] - acc); else passed++;
    total++; if (map_n - m0 !== 2) $display("FAIL bios_map_n got %0d exp 2", map_n - m0); else passed++;
    total++; if (lm_cyc[m0] !== acc + 3) $display("FAIL bios_map_lat got %0d exp 3", lm_cyc[m0] - acc); else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (lm_page[m0+i] !== 2'(i) || lm_off[m0+i] !== 2'(i) || lm_init[m0+i] !== (i == 0) || lm_id[m0+i] !== 4'd0 || lm_slot[m0+i] !== 2'd0 || lm_sub[m0+i] !== 2'd0)
        $display("FAIL bios_map%0d got pg%0d off%0d init%b id%0d exp pg%0d off%0d init%b id0", i, lm_page[m0+i], lm_off[m0+i], lm_init[m0+i], lm_id[m0+i], i, i, i == 0);
      else passed++;
    end
    @(negedge clk); @(negedge clk);
    total++; if (copy_req !== 1'b1 || copy_src !== 28'h0100000) $display("FAIL bios_req_hold got %b/%h exp 1/0100000", copy_req, copy_src); else passed++;
    copy_ack = 1'b1;
    @(negedge clk); copy_ack = 1'b0;
    total++; if (copy_req !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL bios_after_ack got req%b rdy%b exp 0/0", copy_req, cfg_ready); else passed++;
    @(negedge clk); copy_done = 1'b1;
    @(negedge clk); copy_done = 1'b0;
    total++; if (cfg_ready !== 1'b1 || done !== 1'b0) $display("FAIL bios_idle got rdy%b done%b exp 1/0", cfg_ready, done); else passed++;
    total++; if (copy_n - c0 !== 1) $display("FAIL bios_copy_n got %0d exp 1", copy_n - c0); else passed++;
  endtask

  task automatic test_ram_mapper();
    int b0 = blk_n, m0 = map_n, c0 = copy_n, acc; bit ok;
    send(T_RAM, 8'd8, 2'd2, 2'd1, 2'd0, 1'b1, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (!ok || cfg_ready !== 1'b1) $display("FAIL ram_settle got rdy%b exp 1", cfg_ready); else passed++;
    total++; if (lb_id[b0] !== 4'd1 || lb_typ[b0] !== 2'd0 || lb_cnt[b0] !== 8'd8 || lb_off[b0] !== 25'h0008000) $display("FAIL ram_blk got id%0d typ%0d cnt%0d off%h exp id1 typ0 cnt8 off0008000", lb_id[b0], lb_typ[b0], lb_cnt[b0], lb_off[b0]); else passed++;
    total++; if (map_n - m0 !== 4) $display("FAIL ram_map_n got %0d exp 4", map_n - m0); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (lm_page[m0+i] !== 2'(i) || lm_off[m0+i] !== 2'(i) || lm_init[m0+i] !== (i == 0) || lm_id[m0+i] !== 4'd1 || lm_slot[m0+i] !== 2'd2 || lm_sub[m0+i] !== 2'd1)
        $display("FAIL ram_map%0d got pg%0d off%0d init%b id%0d s%0d ss%0d exp pg%0d off%0d id1 s2 ss1", i, lm_page[m0+i], lm_off[m0+i], lm_init[m0+i], lm_id[m0+i], lm_slot[m0+i], lm_sub[m0+i], i, i);
      else passed++;
    end
    total++; if (copy_n !== c0) $display("FAIL ram_no_copy got %0d exp 0", copy_n - c0); else passed++;
  endtask

  task automatic test_cart_clip();
    int b0 = blk_n, m0 = map_n, acc, cc; bit ok;
    send(T_CARTA, 8'd4, 2'd1, 2'd3, 2'd1, 1'b0, 28'h0200000, 1'b0, acc);
    wait_copy(ok, cc);
    total++; if (!ok || copy_dst !== 25'h0028000 || copy_len !== 8'd4 || copy_src !== 28'h0200000) $display("FAIL cart_copy got %h/%0d/%h exp 0028000/4/0200000", copy_dst, copy_len, copy_src); else passed++;
    total++; if (lb_id[b0] !== 4'd2 || lb_typ[b0] !== 2'd1 || lb_off[b0] !== 25'h0028000) $display("FAIL cart_blk got id%0d typ%0d off%h exp id2 typ1 off0028000", lb_id[b0], lb_typ[b0], lb_off[b0]); else passed++;
    total++; if (map_n - m0 !== 3) $display("FAIL cart_map_n got %0d exp 3", map_n - m0); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (lm_page[m0+i] !== 2'(i + 1) || lm_off[m0+i] !== 2'(i) || lm_init[m0+i] !== (i == 0) || lm_id[m0+i] !== 4'd2)
        $display("FAIL cart_map%0d got pg%0d off%0d init%b id%0d exp pg%0d off%0d id2", i, lm_page[m0+i], lm_off[m0+i], lm_init[m0+i], lm_id[m0+i], i + 1, i);
      else passed++;
    end
    copy_ack = 1'b1; copy_done = 1'b1;
    @(negedge clk); copy_ack = 1'b0; copy_done = 1'b0;
    total++; if (cfg_ready !== 1'b1 || copy_req !== 1'b0) $display("FAIL cart_ack_done got rdy%b req%b exp 1/0", cfg_ready, copy_req); else passed++;
  endtask

  task automatic test_start_abort();
    int b0, m0, acc, cc; bit ok;
    send(T_BIOS, 8'd1, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0300000, 1'b0, acc);
    wait_copy(ok, cc);
    copy_ack = 1'b1;
    @(negedge clk); copy_ack = 1'b0;
    total++; if (!ok || copy_req !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL abort_wait got req%b rdy%b exp 0/0", copy_req, cfg_ready); else passed++;
    pulse_start();
    total++; if (cfg_ready !== 1'b1 || done !== 1'b0 || err !== 2'd0 || copy_req !== 1'b0) $display("FAIL abort_idle got rdy%b done%b err%0d exp 1/0/0", cfg_ready, done, err); else passed++;
    b0 = blk_n; m0 = map_n;
    copy_done = 1'b1;
    @(negedge clk); copy_done = 1'b0;
    @(negedge clk);
    total++; if (cfg_ready !== 1'b1 || blk_n !== b0 || map_n !== m0) $display("FAIL abort_stale_done got rdy%b writes%0d exp 1/0", cfg_ready, blk_n - b0 + map_n - m0); else passed++;
    send(T_RAM, 8'd1, 2'd0, 2'd0, 2'd2, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (lb_id[b0] !== 4'd0 || lb_off[b0] !== 25'd0) $display("FAIL abort_realloc got id%0d off%h exp id0 off0", lb_id[b0], lb_off[b0]); else passed++;
    total++; if (lm_page[m0] !== 2'd2 || lm_off[m0] !== 2'd0 || lm_id[m0] !== 4'd0) $display("FAIL abort_map got pg%0d off%0d id%0d exp pg2 off0 id0", lm_page[m0], lm_off[m0], lm_id[m0]); else passed++;
  endtask

  task automatic test_fdc();
    int b0 = blk_n, m0 = map_n, c0 = copy_n, acc; bit ok;
    send(T_FDC, 8'd3, 2'd3, 2'd0, 2'd0, 1'b0, 28'h0400000, 1'b0, acc);
    wait_settle(ok);
    total++; if (lb_id[b0] !== 4'd1 || lb_typ[b0] !== 2'd2 || lb_cnt[b0] !== 8'd3 || lb_off[b0] !== 25'd0) $display("FAIL fdc_blk got id%0d typ%0d cnt%0d off%h exp id1 typ2 cnt3 off0", lb_id[b0], lb_typ[b0], lb_cnt[b0], lb_off[b0]); else passed++;
    total++; if (map_n - m0 !== 3) $display("FAIL fdc_map_n got %0d exp 3", map_n - m0); else passed++;
    send(T_RAM, 8'd1, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (lb_id[b0+1] !== 4'd2 || lb_off[b0+1] !== 25'h0004000) $display("FAIL fdc_no_sdram got id%0d off%h exp id2 off0004000", lb_id[b0+1], lb_off[b0+1]); else passed++;
    send(T_FDC, 8'd1, 2'd1, 2'd0, 2'd3, 1'b0, 28'h0500000, 1'b1, acc);
    wait_settle(ok);
    total++; if (done !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL fdc_last got done%b rdy%b exp 1/0", done, cfg_ready); else passed++;
    total++; if (lb_id[b0+2] !== 4'd3 || lb_typ[b0+2] !== 2'd2 || lb_off[b0+2] !== 25'd0) $display("FAIL fdc_last_blk got id%0d typ%0d off%h exp id3 typ2 off0", lb_id[b0+2], lb_typ[b0+2], lb_off[b0+2]); else passed++;
    total++; if (copy_n !== c0) $display("FAIL fdc_no_copy got %0d exp 0", copy_n - c0); else passed++;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL done_sticky got %b exp 1", done); else passed++;
    pulse_start();
    total++; if (done !== 1'b0 || cfg_ready !== 1'b1) $display("FAIL done_clear got done%b rdy%b exp 0/1", done, cfg_ready); else passed++;
  endtask

  task automatic test_err_zero();
    int b0 = blk_n, m0 = map_n, acc; bit ok;
    send(T_RAM, 8'd0, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (err !== 2'd3 || cfg_ready !== 1'b0) $display("FAIL err_zero got err%0d rdy%b exp 3/0", err, cfg_ready); else passed++;
    @(negedge clk);
    cfg_typ = T_RAM; cfg_block_count = 8'd1; cfg_valid = 1'b1;
    repeat (3) @(negedge clk);
    cfg_valid = 1'b0;
    total++; if (err !== 2'd3 || cfg_ready !== 1'b0 || blk_n !== b0 || map_n !== m0) $display("FAIL err_zero_hold got err%0d rdy%b writes%0d exp 3/0/0", err, cfg_ready, blk_n - b0 + map_n - m0); else passed++;
    pulse_start();
    total++; if (err !== 2'd0 || cfg_ready !== 1'b1) $display("FAIL err_clear got err%0d rdy%b exp 0/1", err, cfg_ready); else passed++;
  endtask

  task automatic test_err_ids();
    int b0 = blk_n, acc; bit ok;
    send(T_NONE, 8'd5, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (blk_n !== b0 || cfg_ready !== 1'b1) $display("FAIL none_discard got writes%0d rdy%b exp 0/1", blk_n - b0, cfg_ready); else passed++;
    for (int i = 0; i < 16; i++) begin
      send(T_FDC, 8'd1, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
      wait_settle(ok);
    end
    total++; if (blk_n - b0 !== 16 || lb_id[b0+15] !== 4'd15) $display("FAIL ids_fill got n%0d last%0d exp 16/15", blk_n - b0, lb_id[b0+15]); else passed++;
    send(T_RAM, 8'd1, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (err !== 2'd1 || cfg_ready !== 1'b0 || blk_n - b0 !== 16) $display("FAIL err_ids got err%0d rdy%b n%0d exp 1/0/16", err, cfg_ready, blk_n - b0); else passed++;
    pulse_start();
  endtask

  task automatic test_err_sdram();
    int b0 = blk_n, acc; bit ok;
    for (int i = 0; i < 8; i++) begin
      send(T_RAM, 8'd255, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
      wait_settle(ok);
    end
    send(T_RAM, 8'd8, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (err !== 2'd0 || blk_n - b0 !== 9 || lb_off[b0+8] !== 25'h1FE0000) $display("FAIL sdram_exact got err%0d n%0d off%h exp 0/9/1FE0000", err, blk_n - b0, lb_off[b0+8]); else passed++;
    send(T_RAM, 8'd1, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (err !== 2'd2 || cfg_ready !== 1'b0 || blk_n - b0 !== 9) $display("FAIL err_sdram got err%0d rdy%b n%0d exp 2/0/9", err, cfg_ready, blk_n - b0); else passed++;
    pulse_start();
  endtask

  task automatic test_reset_midop();
    int b0, acc; bit ok, seen;
    send(T_RAM, 8'd8, 2'd0, 2'd0, 2'd0, 1'b1, 28'h0, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (map_we) seen = 1'b1; else @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    total++; if (!seen || cfg_ready !== 1'b1 || map_we !== 1'b0 || blk_we !== 1'b0) $display("FAIL reset_async got seen%b rdy%b map_we%b exp 1/1/0", seen, cfg_ready, map_we); else passed++;
    @(negedge clk); reset = 1'b0;
    b0 = blk_n;
    send(T_RAM, 8'd1, 2'd0, 2'd0, 2'd0, 1'b0, 28'h0, 1'b0, acc);
    wait_settle(ok);
    total++; if (lb_id[b0] !== 4'd0 || lb_off[b0] !== 25'd0) $display("FAIL reset_realloc got id%0d off%h exp id0 off0", lb_id[b0], lb_off[b0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_bios();
    test_ram_mapper();
    test_cart_clip();
    test_start_abort();
    test_fdc();
    test_err_zero();
    test_err_ids();
    test_err_sdram();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
